buzina_farol: RTL
=================

# buzina_farol

Audible driver for the headlight-on warning. It consumes the combinational warning request from the headlight warning signaler and turns it into a timed beep pattern on a buzzer output. The pattern is bursts of beeps separated by longer pauses. A driver silence input mutes the pattern until the request clears. The block sits between the signaler and the buzzer transistor stage, and is the sequential consumer of the warning signal.

## Interface
- T_ON, 250: buzzer-on cycles per beep (≥1)
- T_OFF, 250: gap cycles between beeps within a burst (≥1)
- N_BIPS, 3: beeps per burst (≥1)
- T_PAUSA, 1000: silent cycles between bursts (≥1)
- clock  input  1  single system clock, rising edge
- reset  input  1  synchronous, active-high; sampled on the rising edge of clock
- sinal  input  1  warning request (1 = headlight on with door open or key out); synchronous to clock
- silenciar  input  1  driver mute request; level, synchronous to clock
- buzina  output  1  buzzer drive (1 = sounding)
- ativo  output  1  1 while the beep pattern is running (LIGADO, DESLIGADO or PAUSA)
- silenciado  output  1  1 while in SILENCIADO

## Operation
- States: REPOUSO, LIGADO, DESLIGADO, PAUSA, SILENCIADO.
- All outputs are Moore decodes of the registered state:
  - buzina = (LIGADO)
  - ativo = (LIGADO | DESLIGADO | PAUSA)
  - silenciado = (SILENCIADO)
- Registers: state; tempo, a cycle counter of width $clog2(max(T_ON,T_OFF,T_PAUSA)+1); bips, a beep counter of width $clog2(N_BIPS+1).
- Priority at each edge: reset > sinal=0 > silenciar=1 > timer transitions.
- REPOUSO:
  - sinal=1, silenciar=0 -> LIGADO, tempo=0, bips=0.
  - sinal=1, silenciar=1 -> SILENCIADO. No beep is produced.
  - sinal=0 -> stay.
- LIGADO: tempo increments each cycle. When tempo==T_ON-1, tempo clears and bips increments.
  - If bips==N_BIPS-1 -> PAUSA.
  - Otherwise -> DESLIGADO.
- DESLIGADO: when tempo==T_OFF-1 -> LIGADO, tempo=0.
- PAUSA: when tempo==T_PAUSA-1 -> LIGADO, tempo=0, bips=0.
- LIGADO, DESLIGADO, PAUSA:
  - sinal=0 -> REPOUSO, counters cleared.
  - silenciar=1 (with sinal=1) -> SILENCIADO, counters cleared.
- SILENCIADO: holds regardless of silenciar. sinal=0 -> REPOUSO. A new rising request after that restarts the full pattern.
- N_BIPS=1: every beep is followed by PAUSA, and DESLIGADO is never entered.
- Counters never wrap. Each is cleared on its terminal count, before reaching 2^width.

## Timing
- Reset: state=REPOUSO, tempo=0, bips=0, buzina=0, ativo=0, silenciado=0. Values are valid from the first cycle after the reset edge.
- Reset asserted mid-pattern forces REPOUSO at that edge, even if sinal=1. With sinal still 1 after reset releases, the first beep starts one cycle after the first non-reset edge.
- Latency from sinal sampled high (in REPOUSO) to buzina=1 is 1 cycle.
- Latency from sinal sampled low to buzina=0 and ativo=0 is 1 cycle, from any state.
- Latency from silenciar sampled high to buzina=0 and silenciado=1 is 1 cycle.
- Steady pattern with sinal held high: T_ON high, T_OFF low, repeated N_BIPS times. The final T_OFF of each burst is replaced by T_PAUSA low. Burst period is N_BIPS·T_ON + (N_BIPS-1)·T_OFF + T_PAUSA cycles.
- sinal and silenciar are already synchronous to clock. No synchronizer or debouncer is inside the block.
- Simultaneous events on the same edge:
  - sinal=0 with silenciar=1 -> REPOUSO.
  - sinal=0 on a timer terminal count -> REPOUSO.
  - silenciar=1 on a terminal count -> SILENCIADO.

## Test plan
All scenarios use T_ON=2, T_OFF=3, N_BIPS=2, T_PAUSA=5 unless stated.
- Reset, then sinal=0 for 10 cycles -> buzina=0, ativo=0, silenciado=0 throughout.
- sinal=1 held for 40 cycles -> from the next cycle buzina follows 1,1,0,0,0,1,1,0,0,0,0,0, repeating with period 12. ativo=1 from cycle 1 onward.
- sinal=1, then silenciar=1 pulsed for 1 cycle during the 2nd beep -> buzina=0 and silenciado=1 on the next cycle, and both hold while sinal=1. Then sinal=0 -> silenciado=0 next cycle. Then sinal=1 -> the pattern restarts from the first beep.
- sinal=1 for 7 cycles, then sinal=0 during the 2nd beep -> buzina and ativo are 0 on the next cycle. sinal=1 again -> buzina=1 after 1 cycle, and a full 2-beep burst follows (bips was cleared).
- reset=1 for 1 cycle during PAUSA with sinal held at 1 -> outputs 0 on the cycle after reset. Pattern restarts one cycle after reset releases.
- Rerun with N_BIPS=1, T_PAUSA=1 under the same stimulus as scenario 2 -> buzina follows 1,1,0 with period 3. DESLIGADO is never entered, checked by state assertion.

Source files
------------

// File: rtl/buzina_farol_if.sv
// Warning-request / buzzer bus between the headlight signaler side and
// the buzzer driver. The master drives the request and mute inputs; the
// slave (buzina_farol) drives the buzzer and status outputs.
interface buzina_farol_if;
   logic sinal;
   logic silenciar;
   logic buzina;
   logic ativo;
   logic silenciado;

   modport master (
      output sinal,
      output silenciar,
      input  buzina,
      input  ativo,
      input  silenciado
   );

   modport slave (
      input  sinal,
      input  silenciar,
      output buzina,
      output ativo,
      output silenciado
   );
endinterface

// File: rtl/buzina_farol.sv
// Headlight-on warning buzzer driver. Turns the warning request into
// bursts of N_BIPS beeps (T_ON on, T_OFF gap) separated by T_PAUSA of
// silence. A mute request holds the buzzer silent until the request
// drops. Outputs are registered Moore decodes of the state.
module buzina_farol #(
   parameter int T_ON    = 250,
   parameter int T_OFF   = 250,
   parameter int N_BIPS  = 3,
   parameter int T_PAUSA = 1000
) (
   input  logic            clock,
   input  logic            reset,
   buzina_farol_if.slave   bus
);

   localparam int T_MAX1 = (T_ON > T_OFF) ? T_ON : T_OFF;
   localparam int T_MAX  = (T_MAX1 > T_PAUSA) ? T_MAX1 : T_PAUSA;
   localparam int TW     = (T_MAX > 1) ? $clog2(T_MAX + 1) : 1;
   localparam int BW     = $clog2(N_BIPS + 1);

   localparam logic [TW-1:0] T_ON_FIM    = TW'(T_ON - 1);
   localparam logic [TW-1:0] T_OFF_FIM   = TW'(T_OFF - 1);
   localparam logic [TW-1:0] T_PAUSA_FIM = TW'(T_PAUSA - 1);
   localparam logic [BW-1:0] BIPS_FIM    = BW'(N_BIPS - 1);
   localparam logic [TW-1:0] TEMPO_ZERO  = {TW{1'b0}};
   localparam logic [BW-1:0] BIPS_ZERO   = {BW{1'b0}};
   localparam logic [TW-1:0] TEMPO_UM    = {{(TW-1){1'b0}}, 1'b1};
   localparam logic [BW-1:0] BIPS_UM     = {{(BW-1){1'b0}}, 1'b1};

   // Explicit encoding so the state can be inspected by value.
   typedef enum logic [2:0] {
      REPOUSO    = 3'd0,
      LIGADO     = 3'd1,
      DESLIGADO  = 3'd2,
      PAUSA      = 3'd3,
      SILENCIADO = 3'd4
   } estado_t;

   estado_t       state_q, state_d;
   logic [TW-1:0] tempo_q, tempo_d;
   logic [BW-1:0] bips_q,  bips_d;
   logic          buzina_q;
   logic          ativo_q;
   logic          silenciado_q;

   // Next-state and counter logic; request loss beats mute, mute beats timers.
   always_comb begin
      state_d = state_q;
      tempo_d = tempo_q;
      bips_d  = bips_q;
      case (state_q)
         REPOUSO: begin
            if (bus.sinal) begin
               if (bus.silenciar) begin
                  state_d = SILENCIADO;
               end else begin
                  state_d = LIGADO;
               end
               tempo_d = TEMPO_ZERO;
               bips_d  = BIPS_ZERO;
            end else begin
               state_d = REPOUSO;
            end
         end
         LIGADO, DESLIGADO, PAUSA: begin
            if (!bus.sinal) begin
               state_d = REPOUSO;
               tempo_d = TEMPO_ZERO;
               bips_d  = BIPS_ZERO;
            end else if (bus.silenciar) begin
               state_d = SILENCIADO;
               tempo_d = TEMPO_ZERO;
               bips_d  = BIPS_ZERO;
            end else begin
               case (state_q)
                  LIGADO: begin
                     if (tempo_q == T_ON_FIM) begin
                        tempo_d = TEMPO_ZERO;
                        bips_d  = bips_q + BIPS_UM;
                        if (bips_q == BIPS_FIM) begin
                           state_d = PAUSA;
                        end else begin
                           state_d = DESLIGADO;
                        end
                     end else begin
                        tempo_d = tempo_q + TEMPO_UM;
                     end
                  end
                  DESLIGADO: begin
                     if (tempo_q == T_OFF_FIM) begin
                        state_d = LIGADO;
                        tempo_d = TEMPO_ZERO;
                     end else begin
                        tempo_d = tempo_q + TEMPO_UM;
                     end
                  end
                  PAUSA: begin
                     if (tempo_q == T_PAUSA_FIM) begin
                        state_d = LIGADO;
                        tempo_d = TEMPO_ZERO;
                        bips_d  = BIPS_ZERO;
                     end else begin
                        tempo_d = tempo_q + TEMPO_UM;
                     end
                  end
                  default: begin
                     state_d = REPOUSO;
                  end
               endcase
            end
         end
         SILENCIADO: begin
            if (!bus.sinal) begin
               state_d = REPOUSO;
            end else begin
               state_d = SILENCIADO;
            end
            tempo_d = TEMPO_ZERO;
            bips_d  = BIPS_ZERO;
         end
         default: begin
            state_d = REPOUSO;
            tempo_d = TEMPO_ZERO;
            bips_d  = BIPS_ZERO;
         end
      endcase
   end

   // State, counters and output registers; outputs decode the next state so
   // they always match the registered state.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= REPOUSO;
         tempo_q      <= TEMPO_ZERO;
         bips_q       <= BIPS_ZERO;
         buzina_q     <= 1'b0;
         ativo_q      <= 1'b0;
         silenciado_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         tempo_q      <= tempo_d;
         bips_q       <= bips_d;
         buzina_q     <= (state_d == LIGADO);
         ativo_q      <= (state_d == LIGADO) || (state_d == DESLIGADO) ||
                         (state_d == PAUSA);
         silenciado_q <= (state_d == SILENCIADO);
      end
   end

   assign bus.buzina     = buzina_q;
   assign bus.ativo      = ativo_q;
   assign bus.silenciado = silenciado_q;

endmodule
